// File: rtl/fetch_queue.sv
// Instruction prefetch queue: circular buffer of {pc, inst} between fetch and decode.
// Optional macro FETCHQ_BYPASS_EN adds a zero-latency empty-queue bypass to decode.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic [63:0]      head;
  logic             stored_vld;
  logic             byp_vld;
  logic             byp_take;
  logic             push;
  logic             pop;

  assign stored_vld = (cnt != '0);

`ifdef FETCHQ_BYPASS_EN
  assign byp_vld = !stored_vld && in_valid && !flush;
`else
  assign byp_vld = 1'b0;
`endif

  // A bypassed entry consumed in the same cycle never touches storage.
  assign byp_take  = byp_vld && out_ready;
  assign in_ready  = (cnt != CNT_FULL);
  assign out_valid = stored_vld || byp_vld;
  assign push      = in_valid && in_ready && !flush && !byp_take;
  assign pop       = stored_vld && out_ready && !flush;

  assign head     = mem[rd_ptr];
  assign out_inst = stored_vld ? head[31:0]  : (byp_vld ? in_inst : 32'h0000_0000);
  assign out_pc   = stored_vld ? head[63:32] : (byp_vld ? in_pc   : 32'h0000_0000);
  assign count    = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage carries no reset; only pointers and occupancy qualify it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_pc, in_inst};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
// Build with +define+FETCHQ_BYPASS_EN to exercise the bypass configuration.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_inst = '0;
  logic [31:0]      in_pc = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_inst;
  logic [31:0]      out_pc;
  logic [PTR_W:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] q[$];

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .count(count)
  );

  always #5 clk = ~clk;

  // Model expectations for the current cycle, from queue contents and driven inputs.
  function automatic bit byp_now();
    return BYP && q.size() == 0 && in_valid && !flush;
  endfunction
  function automatic logic exp_valid();
    return q.size() > 0 || byp_now();
  endfunction
  function automatic logic [31:0] exp_inst();
    if (q.size() > 0) return q[0][31:0];
    return byp_now() ? in_inst : 32'h0;
  endfunction
  function automatic logic [31:0] exp_pc();
    if (q.size() > 0) return q[0][63:32];
    return byp_now() ? in_pc : 32'h0;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    #2;
  endtask

  // Advance one clock edge, applying the queue rules to the model.
  task automatic tick();
    bit full_before;
    full_before = (q.size() >= DEPTH);
    if (flush) q.delete();
    else if (!(byp_now() && out_ready)) begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && !full_before) q.push_back({in_pc, in_inst});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h40 + 32'(i*4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    rst = 1'b1;
    q.delete();
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", count); end
    idle();
    n_checks++; if (out_inst !== 32'h0 || out_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_out_word got inst=%h pc=%h want 0/0", out_inst, out_pc); end
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_full();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i*4), 32'h1000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    idle();
    n_checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_state got count=%0d in_ready=%b want 4/0", count, in_ready); end
    drive(1'b1, 32'h10, 32'h1004, 1'b0, 1'b0);
    tick();
    idle();
    n_checks++; if (count !== 3'd4 || out_pc !== 32'h0) begin
      n_fail++; $display("FAIL full_refuse got count=%0d head=%h want 4/00000000", count, out_pc); end
    drive(1'b1, 32'h10, 32'h1004, 1'b1, 1'b0);
    tick();
    idle();
    n_checks++; if (count !== 3'd3 || out_pc !== 32'h4) begin
      n_fail++; $display("FAIL full_pop got count=%0d head=%h want 3/00000004", count, out_pc); end
    drive(1'b1, 32'h10, 32'h1004, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4 + i*4) || out_inst !== 32'h1001 + 32'(i)) begin
        n_fail++; $display("FAIL full_drain%0d got v=%b pc=%h inst=%h want pc=%h", i, out_valid, out_pc, out_inst, 32'(4 + i*4)); end
      tick();
    end
    idle();
    n_checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL full_empty got v=%b count=%0d want 0/0", out_valid, count); end
  endtask

  task automatic test_wrap_stream();
    for (int i = 0; i < 21; i++) begin
      logic [31:0] want_pc;
      bit want_v;
      if (i < 20) drive(1'b1, 32'(i*4), 32'h2000 + 32'(i), 1'b1, 1'b0);
      else        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      want_v  = BYP ? (i < 20) : (i > 0);
      want_pc = BYP ? 32'(i*4) : 32'((i-1)*4);
      if (want_v) begin
        n_checks++; if (out_valid !== 1'b1 || out_pc !== want_pc) begin
          n_fail++; $display("FAIL stream%0d got v=%b pc=%h want 1/%h", i, out_valid, out_pc, want_pc); end
      end
      if (i > 0 && i < 20) begin
        n_checks++; if (count !== (BYP ? 3'd0 : 3'd1)) begin
          n_fail++; $display("FAIL stream_count%0d got=%0d want=%0d", i, count, BYP ? 0 : 1); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h80 + 32'(i*4), 32'h3000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h200, 32'h3FFF, 1'b1, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h80) begin
      n_fail++; $display("FAIL flush_cycle_head got v=%b pc=%h want 1/00000080", out_valid, out_pc); end
    tick();
    idle();
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_after got count=%0d v=%b want 0/0", count, out_valid); end
    drive(1'b1, 32'h100, 32'h3100, 1'b0, 1'b0);
    tick();
    idle();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== 32'h3100 || count !== 3'd1) begin
      n_fail++; $display("FAIL flush_next got v=%b pc=%h inst=%h count=%0d want 1/00000100/00003100/1", out_valid, out_pc, out_inst, count); end
    drain();
  endtask

  task automatic test_full_pop_push();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hC0 + 32'(i*4), 32'h4000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'hF0, 32'h40FF, 1'b1, 1'b0);
    tick();
    idle();
    n_checks++; if (count !== 3'd3 || out_pc !== 32'hC4 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_poppush got count=%0d head=%h rdy=%b want 3/000000c4/1", count, out_pc, in_ready); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      n_checks++; if (out_pc !== 32'hC4 + 32'(i*4)) begin
        n_fail++; $display("FAIL poppush_drain%0d got pc=%h want %h", i, out_pc, 32'hC4 + 32'(i*4)); end
      tick();
    end
    idle();
  endtask

`ifdef FETCHQ_BYPASS_EN
  task automatic test_bypass();
    drive(1'b1, 32'h500, 32'h8C21_0001, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_inst !== 32'h8C21_0001 || out_pc !== 32'h500 || count !== 3'd0) begin
      n_fail++; $display("FAIL bypass_take got v=%b inst=%h pc=%h count=%0d", out_valid, out_inst, out_pc, count); end
    tick();
    idle();
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bypass_nostore got count=%0d v=%b want 0/0", count, out_valid); end
    drive(1'b1, 32'h504, 32'h8C21_0001, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_inst !== 32'h8C21_0001) begin
      n_fail++; $display("FAIL bypass_stall got v=%b inst=%h", out_valid, out_inst); end
    tick();
    idle();
    n_checks++; if (count !== 3'd1 || out_pc !== 32'h504) begin
      n_fail++; $display("FAIL bypass_store got count=%0d pc=%h want 1/00000504", count, out_pc); end
    drain();
  endtask
`endif

  task automatic test_random();
    logic [31:0] pc = 32'h1_0000;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, pc, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0);
      n_checks++;
      if (out_valid !== exp_valid() || (exp_valid() && (out_inst !== exp_inst() || out_pc !== exp_pc()))
          || count !== 3'(q.size()) || in_ready !== (q.size() < DEPTH)) begin
        n_fail++;
        $display("FAIL random%0d got v=%b inst=%h pc=%h cnt=%0d rdy=%b want v=%b inst=%h pc=%h cnt=%0d",
                 i, out_valid, out_inst, out_pc, count, in_ready, exp_valid(), exp_inst(), exp_pc(), q.size());
      end
      if (in_valid && in_ready) pc = pc + 32'd4;
      tick();
    end
    idle();
  endtask

  initial begin
    #3;
    idle();
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_fill_full();
    test_wrap_stream();
    test_flush();
    test_full_pop_push();
`ifdef FETCHQ_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
